mac_engine: RTL and testbench
=============================

MAC_ENGINE -- requirements
Module: mac_engine

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning number of requester channels (control, inversion, mat_mult).
REQ-002 SHALL have parameter WIDTH, default 32, meaning operand and result width, signed two's complement.
REQ-003 SHALL have parameter LEN_W, default 8, meaning width of the per-channel term-count field.
REQ-004 SHALL have parameters F_MODE0/F_MODE1/F_MODE2, defaults 0/16/8, meaning fractional bits applied for mode 0/1/2.
REQ-005 SHALL have parameter GUARD, default 8, meaning accumulator guard bits above WIDTH.
REQ-006 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NUM_CH  per-channel engine request.
- mode  in  3*NUM_CH  packed per-channel mode.
- len  in  LEN_W*NUM_CH  packed per-channel term count.
- gnt  out  NUM_CH  one-hot grant.
- in_1, in_2  in  WIDTH*NUM_CH  packed operands.
- in_valid  in  NUM_CH  operand valid.
- in_ready  out  NUM_CH  operand ready.
- out  out  WIDTH  dot-product result.
- out_valid  out  1  result strobe.
- out_ch  out  $clog2(NUM_CH)  channel owning out.
- out_sat  out  1  result saturated.
- busy  out  1  engine not IDLE.

Function
REQ-007 SHALL implement FSM states IDLE, ACC, DRAIN, OUT; busy = (state != IDLE).
REQ-008 IDLE: if any req bit set, SHALL grant round-robin starting at the channel after the last granted, latch that channel's mode and len, clear the accumulator, and enter ACC; gnt rises the cycle after the decision.
REQ-009 SHALL hold gnt one-hot for the granted channel throughout ACC, DRAIN and OUT, and all-zero in IDLE.
REQ-010 ACC: in_ready SHALL equal gnt while the accepted count < latched len; a beat is accepted when in_valid & in_ready on the granted channel.
REQ-011 Other channels' in_valid/operands SHALL be ignored.
REQ-012 On acceptance of beat number len, SHALL enter DRAIN.
REQ-013 Pipeline: product in_1*in_2 (2*WIDTH signed) registered in stage 1.
REQ-014 Stage 1 SHALL arithmetic-shift the product right by the mode's F (truncation toward -inf).
REQ-015 Stage 2 SHALL add the shifted product into a WIDTH+GUARD signed accumulator, wrapping within the accumulator.
REQ-016 Mode values 3..7 SHALL behave as mode 0.
REQ-017 DRAIN SHALL last exactly 2 cycles, then enter OUT; out_valid SHALL assert in the third cycle after the last accepted beat.
REQ-018 OUT: one cycle; out_valid=1, out_ch=granted index.
REQ-019 OUT: out = accumulator saturated to WIDTH signed range; out_sat=1 iff clamping occurred.
REQ-020 OUT: then IDLE, gnt cleared, round-robin pointer = granted index.
REQ-021 out, out_ch, out_sat SHALL hold their values until the next OUT; out_valid SHALL be 1 only in OUT; the output has no backpressure.
REQ-022 len=0: ACC SHALL accept no beats and go directly to DRAIN; result is 0, out_sat=0.
REQ-023 req[g] deasserted during ACC or DRAIN SHALL abort: return to IDLE next cycle, no out_valid, pointer = g.
REQ-024 A new grant SHALL NOT be issued in the OUT cycle; the earliest re-grant decision is the IDLE cycle after OUT.
REQ-025 With all channels requesting continuously, each SHALL be served once per NUM_CH transactions.

Reset
REQ-026 While rst=0: state IDLE, gnt=0, in_ready=0, out=0, out_valid=0, out_ch=0, out_sat=0, busy=0, accumulator and pipeline cleared, pointer = NUM_CH-1 (channel 0 wins first).
REQ-027 Reset asserted mid-transaction SHALL abort immediately and asynchronously with no out_valid.

Verification
REQ-028 ch0 mode0 len=3, beats (2,3),(4,5),(-1,7) back-to-back -> out=19, out_ch=0, out_sat=0, out_valid exactly 3 cycles after third beat.
REQ-029 ch1 mode1 len=2, beats (0x00018000,0x00020000),(0x00010000,0x00010000) -> out=0x00040000 (1.5*2+1=4.0 in Q16).
REQ-030 ch2 mode0 len=2, beats (0x7FFFFFFF,2),(0x7FFFFFFF,2) -> out=0x7FFFFFFF, out_sat=1; negative case -> 0x80000000, out_sat=1.
REQ-031 req=3'b111 held with len=1 each -> grants in order ch0, ch1, ch2, ch0; no simultaneous grant bits.
REQ-032 ch1 granted len=4, drop req[1] after 2 beats -> no out_valid, busy=0 next cycle, next grant goes to ch2 if requesting.
REQ-033 rst=0 pulse during DRAIN -> all outputs zero immediately; after release, len=0 request on ch0 -> out=0, out_valid one cycle.

Source files
------------

// File: rtl/mac_engine.sv
// Shared multiply-accumulate engine: round-robin arbitration between requester
// channels, a two-stage fixed-point dot-product pipeline and a saturating result register.
module mac_engine #(
    parameter int NUM_CH  = 3,
    parameter int WIDTH   = 32,
    parameter int LEN_W   = 8,
    parameter int F_MODE0 = 0,
    parameter int F_MODE1 = 16,
    parameter int F_MODE2 = 8,
    parameter int GUARD   = 8
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [NUM_CH-1:0]                                req,
    input  logic [3*NUM_CH-1:0]                              mode,
    input  logic [LEN_W*NUM_CH-1:0]                          len,
    output logic [NUM_CH-1:0]                                gnt,
    input  logic [WIDTH*NUM_CH-1:0]                          in_1,
    input  logic [WIDTH*NUM_CH-1:0]                          in_2,
    input  logic [NUM_CH-1:0]                                in_valid,
    output logic [NUM_CH-1:0]                                in_ready,
    output logic [WIDTH-1:0]                                 out,
    output logic                                             out_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]   out_ch,
    output logic                                             out_sat,
    output logic                                             busy
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = WIDTH + GUARD;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t                    state_q;
    logic [NUM_CH-1:0]         gnt_q;
    logic [CH_W-1:0]           gntIdx_q;
    logic [CH_W-1:0]           ptr_q;
    logic [2:0]                mode_q;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          cnt_q;
    logic                      drain_q;
    logic signed [ACC_W-1:0]   prod_q;
    logic                      prodValid_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [WIDTH-1:0]          out_q;
    logic                      outValid_q;
    logic [CH_W-1:0]           outCh_q;
    logic                      outSat_q;

    logic                      found_d;
    logic [CH_W-1:0]           cand_d;
    logic [CH_W-1:0]           pickIdx_d;
    logic [2:0]                pickMode_d;
    logic [LEN_W-1:0]          pickLen_d;
    logic signed [WIDTH-1:0]   opA_d;
    logic signed [WIDTH-1:0]   opB_d;
    logic signed [2*WIDTH-1:0] fullProd_d;
    logic signed [ACC_W-1:0]   prodShift_d;
    int                        shAmt_d;
    logic                      canTake_d;
    logic                      accept_d;
    logic                      reqG_d;
    logic [WIDTH-1:0]          satVal_d;
    logic                      satFlag_d;

    // Search starts one past the last served channel so every requester gets a turn.
    always_comb begin
        found_d   = 1'b0;
        cand_d    = '0;
        pickIdx_d = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_d = CH_W'((int'(ptr_q) + k) % NUM_CH);
            if (!found_d && req[cand_d]) begin
                found_d   = 1'b1;
                pickIdx_d = cand_d;
            end
        end
    end

    always_comb begin
        pickMode_d = '0;
        pickLen_d  = '0;
        opA_d      = '0;
        opB_d      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == pickIdx_d) begin
                pickMode_d = mode[3*c +: 3];
                pickLen_d  = len[LEN_W*c +: LEN_W];
            end
            if (CH_W'(c) == gntIdx_q) begin
                opA_d = in_1[WIDTH*c +: WIDTH];
                opB_d = in_2[WIDTH*c +: WIDTH];
            end
        end
    end

    always_comb begin
        case (mode_q)
            3'd1:    shAmt_d = F_MODE1;
            3'd2:    shAmt_d = F_MODE2;
            default: shAmt_d = F_MODE0;
        endcase
    end

    assign fullProd_d  = opA_d * opB_d;
    assign prodShift_d = ACC_W'(fullProd_d >>> shAmt_d);

    assign reqG_d    = req[gntIdx_q];
    assign canTake_d = (state_q == S_ACC) && (cnt_q < len_q);
    assign accept_d  = canTake_d && in_valid[gntIdx_q];

    // Clamp when the guard bits plus the result sign bit are not a pure sign extension.
    always_comb begin
        satVal_d  = acc_q[WIDTH-1:0];
        satFlag_d = 1'b0;
        if (!((&acc_q[ACC_W-1:WIDTH-1]) || !(|acc_q[ACC_W-1:WIDTH-1]))) begin
            satFlag_d = 1'b1;
            satVal_d  = acc_q[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            gntIdx_q    <= '0;
            ptr_q       <= CH_W'(NUM_CH - 1);
            mode_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            prod_q      <= '0;
            prodValid_q <= 1'b0;
            acc_q       <= '0;
            out_q       <= '0;
            outValid_q  <= 1'b0;
            outCh_q     <= '0;
            outSat_q    <= 1'b0;
        end else begin
            prodValid_q <= accept_d;
            if (accept_d) begin
                prod_q <= prodShift_d;
            end
            // A fresh grant wins over a stale product left behind by an aborted job.
            if (state_q == S_IDLE && found_d) begin
                acc_q <= '0;
            end else if (prodValid_q) begin
                acc_q <= acc_q + prod_q;
            end
            outValid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        gnt_q    <= NUM_CH'(1) << pickIdx_d;
                        gntIdx_q <= pickIdx_d;
                        mode_q   <= pickMode_d;
                        len_q    <= pickLen_d;
                        cnt_q    <= '0;
                        drain_q  <= 1'b0;
                        state_q  <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (!reqG_d) begin
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                        ptr_q   <= gntIdx_q;
                    end else begin
                        if (accept_d) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if ((cnt_q == len_q) || (accept_d && (cnt_q + 1'b1 == len_q))) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!reqG_d) begin
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                        ptr_q   <= gntIdx_q;
                    end else if (drain_q) begin
                        state_q    <= S_OUT;
                        outValid_q <= 1'b1;
                        out_q      <= satVal_d;
                        outSat_q   <= satFlag_d;
                        outCh_q    <= gntIdx_q;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    ptr_q   <= gntIdx_q;
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign in_ready  = canTake_d ? gnt_q : '0;
    assign out       = out_q;
    assign out_valid = outValid_q;
    assign out_ch    = outCh_q;
    assign out_sat   = outSat_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_engine.sv
// Scoreboard bench for mac_engine: stimulus pushes expected results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_mac_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [8:0]  mode;
    logic [23:0] len;
    logic [2:0]  gnt;
    logic [95:0] in_1;
    logic [95:0] in_2;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [31:0] out;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic        out_sat;
    logic        busy;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  ch;
        logic        sat;
    } exp_t;

    exp_t        sbQ[$];
    exp_t        monExp;
    int          checks   = 0;
    int          failures = 0;
    int          outCount = 0;
    logic [31:0] beatA[8];
    logic [31:0] beatB[8];
    int          rrOrder[4] = '{0, 1, 2, 0};

    always #5 clk = ~clk;

    mac_engine dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .len       (len),
        .gnt       (gnt),
        .in_1      (in_1),
        .in_2      (in_2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [31:0] d, input logic [1:0] ch, input logic sat);
        exp_t e;
        e.data = d;
        e.ch   = ch;
        e.sat  = sat;
        sbQ.push_back(e);
    endtask

    // Any strobe with nothing queued is an output the engine should never have produced.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1) begin
            outCount++;
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output: got out=0x%0h ch=%0d expected no output", out, out_ch);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput("out_data", out, monExp.data);
                checkOutput("out_ch", out_ch, monExp.ch);
                checkOutput("out_sat", out_sat, monExp.sat);
            end
        end
    end

    task automatic applyStimulus(input int ch, input logic [2:0] m, input int n,
                                 input logic [31:0] expData, input logic expSat, input bit checkLat);
        int w;
        int lat;
        pushExp(expData, 2'(ch), expSat);
        mode[3*ch +: 3] = m;
        len[8*ch +: 8]  = 8'(n);
        req[ch]         = 1'b1;
        w = 0;
        while (gnt[ch] !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        checkOutput("grant_onehot", gnt, 3'b001 << ch);
        if (checkLat) checkOutput("grant_latency", w, 1);
        for (int i = 0; i < n; i++) begin
            in_1[32*ch +: 32] = beatA[i];
            in_2[32*ch +: 32] = beatB[i];
            in_valid[ch]      = 1'b1;
            w = 0;
            while (in_ready[ch] !== 1'b1 && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            @(posedge clk); #1;
        end
        in_valid[ch] = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("out_valid_seen", out_valid, 1);
        if (checkLat && n > 0) checkOutput("result_latency", lat, 2);
        req[ch] = 1'b0;
        @(posedge clk); #1;
        checkOutput("strobe_one_cycle", out_valid, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_gnt", gnt, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int oc;
        rst      = 1'b0;
        req      = '0;
        mode     = '0;
        len      = '0;
        in_1     = '0;
        in_2     = '0;
        in_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out", out, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_ch", out_ch, 0);
        checkOutput("rst_out_sat", out_sat, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic dot product on ch0");
        beatA[0] = 32'd2;  beatB[0] = 32'd3;
        beatA[1] = 32'd4;  beatB[1] = 32'd5;
        beatA[2] = -32'sd1; beatB[2] = 32'd7;
        applyStimulus(0, 3'd0, 3, 32'd19, 1'b0, 1'b1);

        $display("[TB] Q16 mode on ch1");
        beatA[0] = 32'h0001_8000; beatB[0] = 32'h0002_0000;
        beatA[1] = 32'h0001_0000; beatB[1] = 32'h0001_0000;
        applyStimulus(1, 3'd1, 2, 32'h0004_0000, 1'b0, 1'b1);

        $display("[TB] saturation on ch2");
        beatA[0] = 32'h7FFF_FFFF; beatB[0] = 32'd2;
        beatA[1] = 32'h7FFF_FFFF; beatB[1] = 32'd2;
        applyStimulus(2, 3'd0, 2, 32'h7FFF_FFFF, 1'b1, 1'b0);
        beatA[0] = 32'h8000_0000; beatB[0] = 32'd2;
        beatA[1] = 32'h8000_0000; beatB[1] = 32'd2;
        applyStimulus(2, 3'd0, 2, 32'h8000_0000, 1'b1, 1'b0);

        $display("[TB] round robin with all channels requesting");
        mode = '0;
        len  = {8'd1, 8'd1, 8'd1};
        in_1 = {32'd4, 32'd2, 32'd5};
        in_2 = {32'd5, 32'd3, 32'd5};
        pushExp(32'd25, 2'd0, 1'b0);
        pushExp(32'd6,  2'd1, 1'b0);
        pushExp(32'd20, 2'd2, 1'b0);
        pushExp(32'd25, 2'd0, 1'b0);
        in_valid = 3'b111;
        req      = 3'b111;
        for (int t = 0; t < 4; t++) begin
            w = 0;
            while (gnt === 3'b000 && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            checkOutput("rr_grant", gnt, 3'b001 << rrOrder[t]);
            checkOutput("rr_onehot", $countones(gnt), 1);
            w = 0;
            while (out_valid !== 1'b1 && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            checkOutput("rr_out_valid", out_valid, 1);
            if (t == 3) req = 3'b000;
            @(posedge clk); #1;
            checkOutput("rr_no_grant_after_out", gnt, 0);
        end
        in_valid = '0;

        $display("[TB] mode aliasing, Q8 truncation and empty job");
        beatA[0] = 32'd3; beatB[0] = 32'hFFFF_FFFC;
        applyStimulus(0, 3'd5, 1, 32'hFFFF_FFF4, 1'b0, 1'b1);
        beatA[0] = 32'h300; beatB[0] = 32'h100;
        beatA[1] = 32'hFFFF_FFFF; beatB[1] = 32'd1;
        applyStimulus(0, 3'd2, 2, 32'h0000_02FF, 1'b0, 1'b1);
        applyStimulus(0, 3'd0, 0, 32'd0, 1'b0, 1'b0);

        $display("[TB] abort on ch1 then ch2 served");
        mode = '0;
        len[8 +: 8]  = 8'd4;
        len[16 +: 8] = 8'd1;
        in_1[64 +: 32] = 32'd3;
        in_2[64 +: 32] = 32'd3;
        in_valid[2] = 1'b1;
        pushExp(32'd9, 2'd2, 1'b0);
        req = 3'b110;
        w = 0;
        while (gnt === 3'b000 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        checkOutput("abort_first_grant", gnt, 3'b010);
        for (int i = 0; i < 2; i++) begin
            in_1[32 +: 32] = 32'(i + 1);
            in_2[32 +: 32] = 32'(i + 1);
            in_valid[1] = 1'b1;
            @(posedge clk); #1;
        end
        req[1]      = 1'b0;
        in_valid[1] = 1'b0;
        oc = outCount;
        @(posedge clk); #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_gnt", gnt, 0);
        @(posedge clk); #1;
        checkOutput("abort_next_grant", gnt, 3'b100);
        w = 0;
        while (out_valid !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        checkOutput("abort_ch2_out_valid", out_valid, 1);
        req[2]      = 1'b0;
        in_valid[2] = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_out_count", outCount - oc, 1);

        $display("[TB] reset during drain");
        mode[0 +: 3] = 3'd0;
        len[0 +: 8]  = 8'd3;
        in_1[0 +: 32] = 32'd1;
        in_2[0 +: 32] = 32'd1;
        req[0] = 1'b1;
        w = 0;
        while (gnt[0] !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        in_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        oc = outCount;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_gnt", gnt, 0);
        checkOutput("mid_rst_out", out, 0);
        checkOutput("mid_rst_out_ch", out_ch, 0);
        checkOutput("mid_rst_out_valid", out_valid, 0);
        req = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("mid_rst_no_output", outCount - oc, 0);
        applyStimulus(0, 3'd0, 0, 32'd0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", sbQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
